// File: rtl/bias_seq_ctrl.sv
// bias_seq_ctrl: per-layer bias buffer sequencer.
// For each output channel: fetch one bias word from SRAM, wait for the read
// data to settle, open the buffer load window for one cycle (bias_read low),
// then hold the bias (bias_valid) until the PE array reports oc_done.
// Optional: define BIAS_SEQ_CTRL_ERR_EN to add the err_sticky output, which
// flags ignored inputs (oc_done outside HOLD, start while busy).
module bias_seq_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int CH_W    = 10,
  parameter int MEM_LAT = 1    // 1..4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CH_W-1:0]   num_oc,
  input  logic              oc_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              bias_read,
  output logic              bias_valid,
  output logic [CH_W-1:0]   oc_idx,
  output logic              busy,
  output logic              layer_done
`ifdef BIAS_SEQ_CTRL_ERR_EN
  , output logic            err_sticky
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   base_r;
  logic [CH_W-1:0]     num_r;
  logic [2:0]          wait_cnt;
  logic [CH_W-1:0]     next_idx;
  logic                last_oc;

  assign next_idx = oc_idx + CH_W'(1);
  // num_r is never zero while in HOLD, so num_r-1 cannot underflow there
  assign last_oc  = (oc_idx == num_r - CH_W'(1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state logic; WAIT lasts MEM_LAT-1 cycles but never less than one,
  // so LOAD closes on the edge where the SRAM data is stable
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (num_oc == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_nx = S_WAIT;
      S_WAIT:  if (wait_cnt <= 3'd1) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_HOLD;
      S_HOLD:  if (oc_done) state_nx = last_oc ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // outputs decoded from the registered state
  always_comb begin
    mem_rd_en  = 1'b0;
    bias_read  = 1'b1;
    bias_valid = 1'b0;
    busy       = 1'b1;
    layer_done = 1'b0;
    case (state)
      S_IDLE:  busy       = 1'b0;
      S_FETCH: mem_rd_en  = 1'b1;
      S_LOAD:  bias_read  = 1'b0;
      S_HOLD:  bias_valid = 1'b1;
      S_DONE:  layer_done = 1'b1;
      default: ;
    endcase
  end

  // layer parameters, channel index, SRAM address and latency counter;
  // mem_addr is loaded on the way into FETCH so it is valid during FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r   <= '0;
      num_r    <= '0;
      oc_idx   <= '0;
      mem_addr <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          base_r <= base_addr;
          num_r  <= num_oc;
          oc_idx <= '0;
          if (num_oc != '0) mem_addr <= base_addr;
        end
        S_FETCH: wait_cnt <= LAT_M1;
        S_WAIT:  if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
        S_HOLD: if (oc_done && !last_oc) begin
          oc_idx   <= next_idx;
          // address wraps modulo 2^ADDR_W
          mem_addr <= base_r + ADDR_W'(next_idx);
        end
        default: ;
      endcase
    end
  end

`ifdef BIAS_SEQ_CTRL_ERR_EN
  // sticky flag for dropped inputs; an accepted start clears it and wins
  // over a coincident oc_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_sticky <= 1'b0;
    else if (state == S_IDLE && start)
      err_sticky <= 1'b0;
    else if ((oc_done && state != S_HOLD) || (start && state != S_IDLE))
      err_sticky <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Bench for bias_seq_ctrl: table of per-cycle vectors on a MEM_LAT=1
// instance, plus hand sequences for mid-layer reset and a MEM_LAT=3 instance.
module tb_bias_seq_ctrl;

  localparam int I = 0, F = 1, W = 2, L = 3, H = 4, D = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // MEM_LAT=1 instance
  logic       st1 = 0, od1 = 0;
  logic [9:0] ba1 = '0, no1 = '0;
  logic       rd1, br1, bv1, bu1, ld1;
  logic [9:0] ad1, ix1;
  // MEM_LAT=3 instance
  logic       st2 = 0, od2 = 0;
  logic [9:0] ba2 = '0, no2 = '0;
  logic       rd2, br2, bv2, bu2, ld2;
  logic [9:0] ad2, ix2;
`ifdef BIAS_SEQ_CTRL_ERR_EN
  logic       er1, er2;
`endif

  bias_seq_ctrl #(.ADDR_W(10), .CH_W(10), .MEM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .base_addr(ba1), .num_oc(no1),
    .oc_done(od1), .mem_rd_en(rd1), .mem_addr(ad1), .bias_read(br1),
    .bias_valid(bv1), .oc_idx(ix1), .busy(bu1), .layer_done(ld1)
`ifdef BIAS_SEQ_CTRL_ERR_EN
    , .err_sticky(er1)
`endif
  );

  bias_seq_ctrl #(.ADDR_W(10), .CH_W(10), .MEM_LAT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .base_addr(ba2), .num_oc(no2),
    .oc_done(od2), .mem_rd_en(rd2), .mem_addr(ad2), .bias_read(br2),
    .bias_valid(bv2), .oc_idx(ix2), .busy(bu2), .layer_done(ld2)
`ifdef BIAS_SEQ_CTRL_ERR_EN
    , .err_sticky(er2)
`endif
  );

  typedef struct {
    logic        st;
    logic [9:0]  ba;
    logic [9:0]  no;
    logic        od;
    logic [31:0] exp;
    logic        er;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  // expected output word for a given FSM state, channel index and address
  function automatic logic [31:0] expv(input int s, input int ix, input int ad);
    return {7'b0, s == F, 10'(ad), s != L, s == H, 10'(ix), s != I, s == D};
  endfunction

  function automatic logic [31:0] act1();
    return {7'b0, rd1, ad1, br1, bv1, ix1, bu1, ld1};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one table row: inputs for the cycle, expected state after the edge
  task automatic row(input int st, input int ba, input int no, input int od,
                     input int s, input int ix, input int ad, input int er);
    vec_t v;
    v.st  = 1'(st);
    v.ba  = 10'(ba);
    v.no  = 10'(no);
    v.od  = 1'(od);
    v.exp = expv(s, ix, ad);
    v.er  = 1'(er);
    tbl.push_back(v);
  endtask

  initial begin
    // layer 1: base 0x010, 3 channels, oc_done 5 cycles after each valid rise
    row(1, 'h010, 3, 0, F, 0, 'h010, 0);
    for (int c = 0; c < 3; c++) begin
      row(0, 0, 0, 0, W, c, 'h010 + c, 0);
      row(0, 0, 0, 0, L, c, 'h010 + c, 0);
      for (int k = 0; k < 5; k++) row(0, 0, 0, 0, H, c, 'h010 + c, 0);
      if (c < 2) row(0, 0, 0, 1, F, c + 1, 'h010 + c + 1, 0);
      else       row(0, 0, 0, 1, D, 2, 'h012, 0);
    end
    row(0, 0, 0, 0, I, 2, 'h012, 0);
    // layer 2: start the cycle after layer_done, new base
    row(1, 'h100, 1, 0, F, 0, 'h100, 0);
    row(0, 0, 0, 0, W, 0, 'h100, 0);
    row(0, 0, 0, 0, L, 0, 'h100, 0);
    row(0, 0, 0, 0, H, 0, 'h100, 0);
    row(0, 0, 0, 1, D, 0, 'h100, 0);
    row(0, 0, 0, 0, I, 0, 'h100, 0);
    // layer 3: zero channels, straight to DONE, no fetch
    row(1, 'h200, 0, 0, D, 0, 'h100, 0);
    row(0, 0, 0, 0, I, 0, 'h100, 0);
    // layer 4: stray oc_done in WAIT, start during HOLD, oc_done in LOAD
    row(1, 'h020, 2, 0, F, 0, 'h020, 0);
    row(0, 0, 0, 0, W, 0, 'h020, 0);
    row(0, 0, 0, 1, L, 0, 'h020, 1);
    row(0, 0, 0, 0, H, 0, 'h020, 1);
    row(1, 'h300, 5, 0, H, 0, 'h020, 1);
    row(0, 0, 0, 1, F, 1, 'h021, 1);
    row(0, 0, 0, 0, W, 1, 'h021, 1);
    row(0, 0, 0, 0, L, 1, 'h021, 1);
    row(0, 0, 0, 1, H, 1, 'h021, 1);
    row(0, 0, 0, 0, H, 1, 'h021, 1);
    row(0, 0, 0, 1, D, 1, 'h021, 1);
    row(0, 0, 0, 0, I, 1, 'h021, 1);
    // layer 5: start with coincident oc_done in IDLE; start wins, flag clears
    row(1, 'h000, 0, 1, D, 0, 'h021, 0);
    row(0, 0, 0, 0, I, 0, 'h021, 0);

    // reset state
    #12;
    chk("reset_u1", act1(), expv(I, 0, 0));
    chk("reset_u2", {7'b0, rd2, ad2, br2, bv2, ix2, bu2, ld2}, expv(I, 0, 0));
`ifdef BIAS_SEQ_CTRL_ERR_EN
    chk("reset_err", 32'(er1), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // table-driven run
    for (int i = 0; i < tbl.size(); i++) begin
      st1 = tbl[i].st; ba1 = tbl[i].ba; no1 = tbl[i].no; od1 = tbl[i].od;
      tick();
      chk($sformatf("row%0d", i), act1(), tbl[i].exp);
`ifdef BIAS_SEQ_CTRL_ERR_EN
      chk($sformatf("row%0d_err", i), 32'(er1), 32'(tbl[i].er));
`endif
    end
    st1 = 0; od1 = 0; ba1 = '0; no1 = '0;

    // reset in HOLD at channel 1 of 4
    st1 = 1; ba1 = 'h040; no1 = 4;
    tick(); st1 = 0;
    chk("rst_seq_fetch0", act1(), expv(F, 0, 'h040));
    tick(); tick(); tick();
    od1 = 1; tick(); od1 = 0;
    chk("rst_seq_fetch1", act1(), expv(F, 1, 'h041));
    tick(); tick(); tick();
    chk("rst_seq_hold1", act1(), expv(H, 1, 'h041));
    rst_n = 1'b0;
    #2;
    chk("rst_async", act1(), expv(I, 0, 0));
`ifdef BIAS_SEQ_CTRL_ERR_EN
    chk("rst_async_err", 32'(er1), 32'd0);
`endif
    #2 rst_n = 1'b1;
    tick();
    chk("rst_idle", act1(), expv(I, 0, 0));
    st1 = 1; ba1 = 'h050; no1 = 1;
    tick(); st1 = 0;
    chk("rst_restart", act1(), expv(F, 0, 'h050));
    tick(); tick(); tick();
    od1 = 1; tick(); od1 = 0;
    chk("rst_restart_done", act1(), expv(D, 0, 'h050));
    tick();

    // MEM_LAT=3: base 0x3FF, 2 channels, address wraps
    st2 = 1; ba2 = 'h3FF; no2 = 2;
    tick(); st2 = 0;
    chk("l3_fetch0", {21'b0, rd2, ad2}, {21'b0, 1'b1, 10'h3FF});
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk($sformatf("l3_c%0d_rd", c), 32'(rd2), 32'd0);
      chk($sformatf("l3_c%0d_read", c), 32'(br2), 32'(c != 4));
      chk($sformatf("l3_c%0d_valid", c), 32'(bv2), 32'(c >= 5));
    end
    od2 = 1; tick(); od2 = 0;
    chk("l3_fetch1", {11'b0, rd2, ad2, ix2}, {11'b0, 1'b1, 10'h000, 10'd1});
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk($sformatf("l3b_c%0d_read", c), 32'(br2), 32'(c != 4));
      chk($sformatf("l3b_c%0d_valid", c), 32'(bv2), 32'(c >= 5));
    end
    od2 = 1; tick(); od2 = 0;
    chk("l3_done", {30'b0, ld2, bu2}, 32'b11);
    tick();
    chk("l3_idle", {30'b0, ld2, bu2}, 32'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
